// File: rtl/or_logic_pkg.sv
// Shared definitions for the OR-logic family: operation width and the
// eight operation codes understood by or_logic_op and its users.
package or_logic_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND    = 3'd0;
    localparam logic [OP_W-1:0] OP_OR     = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA   = 3'd6;
    localparam logic [OP_W-1:0] OP_ACC_OR = 3'd7;

endpackage

// File: rtl/or_logic_op.sv
// Combinational bitwise operation decoder. Produces the result of the
// selected operation on two operands; the accumulating OR also folds in
// the caller's accumulator value. Kept free of state so ALU blocks can
// reuse it directly.
module or_logic_op
    import or_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_r
);

    // Select the bitwise result for the requested operation
    always_comb begin
        o_r = '0;
        case (i_op)
            OP_AND:    o_r = i_a & i_b;
            OP_OR:     o_r = i_a | i_b;
            OP_XOR:    o_r = i_a ^ i_b;
            OP_NAND:   o_r = ~(i_a & i_b);
            OP_NOR:    o_r = ~(i_a | i_b);
            OP_XNOR:   o_r = ~(i_a ^ i_b);
            OP_NOTA:   o_r = ~i_a;
            OP_ACC_OR: o_r = i_acc | i_a | i_b;
            default:   o_r = '0;
        endcase
    end

endmodule

// File: rtl/or_logic_unit_pipe.sv
// Registered bitwise logic stage behind a valid/ready handshake. A single
// output register gives one-cycle latency and full throughput: a new beat
// may be accepted in the same cycle the previous result drains. The
// accumulating OR keeps a running value across beats until a last beat.
module or_logic_unit_pipe
    import or_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_any,
    output logic             y_all,
    output logic             out_last
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_y;
    logic             r_yAny;
    logic             r_yAll;
    logic             r_outLast;
    logic             r_outValid;

    logic [WIDTH-1:0] w_result;
    logic             w_accept;
    logic             w_inReady;

    or_logic_op #(
        .WIDTH (WIDTH)
    ) u_op (
        .i_a   (a),
        .i_b   (b),
        .i_op  (op),
        .i_acc (r_acc),
        .o_r   (w_result)
    );

    // Space is available when the register is empty or is draining now
    assign w_inReady = !r_outValid || out_ready;
    assign w_accept  = in_valid && w_inReady;

    // Result register: load on accept, clear valid on a pure drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_y        <= '0;
            r_yAny     <= 1'b0;
            r_yAll     <= 1'b0;
            r_outLast  <= 1'b0;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_y        <= w_result;
            r_yAny     <= |w_result;
            r_yAll     <= &w_result;
            r_outLast  <= in_last;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Accumulator advances only on accepted accumulating beats; a last
    // beat clears it so the next group starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept && (op == OP_ACC_OR)) begin
            r_acc <= in_last ? '0 : w_result;
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign y         = r_y;
    assign y_any     = r_yAny;
    assign y_all     = r_yAll;
    assign out_last  = r_outLast;

endmodule

// File: tb/tb_or_logic_unit_pipe.sv
// Self-checking bench for or_logic_unit_pipe at WIDTH=8. Expected results
// come from a small reference model and sit in a scoreboard queue whose
// front entry is the result the DUT should currently be presenting.
module tb_or_logic_unit_pipe;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] y;
        logic         any;
        logic         all;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         y_any;
    logic         y_all;
    logic         out_last;

    exp_t         sb[$];
    logic         mValid;
    logic [W-1:0] mAcc;
    int           nChecks;
    int           nPass;

    or_logic_unit_pipe #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_any     (y_any),
        .y_all     (y_all),
        .out_last  (out_last)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference bitwise operation
    function automatic logic [W-1:0] modelOp(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                             input logic [2:0] iop, input logic [W-1:0] iacc);
        case (iop)
            3'd0:    return ia & ib;
            3'd1:    return ia | ib;
            3'd2:    return ia ^ ib;
            3'd3:    return ~(ia & ib);
            3'd4:    return ~(ia | ib);
            3'd5:    return ~(ia ^ ib);
            3'd6:    return ~ia;
            default: return iacc | ia | ib;
        endcase
    endfunction

    function automatic exp_t frontOrX();
        exp_t e;
        e = 'x;
        if (sb.size() > 0) e = sb[0];
        return e;
    endfunction

    // Drive one cycle of stimulus (called just after a falling edge) and
    // advance the model/scoreboard as the coming rising edge will
    task automatic applyStimulus(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic [2:0] iop, input logic il, input logic ordy);
        logic         acc;
        logic [W-1:0] r;
        in_valid  = v;
        a         = ia;
        b         = ib;
        op        = iop;
        in_last   = il;
        out_ready = ordy;
        acc = v && (!mValid || ordy);
        if (mValid && ordy && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
            r = modelOp(ia, ib, iop, mAcc);
            sb.push_back({r, |r, &r, il});
            if (iop == 3'd7) mAcc = il ? '0 : r;
            mValid = 1'b1;
        end else if (ordy) begin
            mValid = 1'b0;
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; op = '0; in_last = 1'b0; out_ready = 1'b0;
        mValid = 1'b0; mAcc = '0; sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 8'h3C, 8'h00, 3'd7, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        e = frontOrX();
        nChecks++;
        if (out_valid !== 1'b1 || y !== 8'h3C) $display("[TB] FAIL reset_preload: valid=%b y=%h want valid=1 y=3c", out_valid, y);
        else nPass++;
        #2 rst = 1'b1;
        #1;
        nChecks++;
        if ({out_valid, y, y_any, y_all, out_last} !== 12'h0)
            $display("[TB] FAIL reset_async: valid=%b y=%h any=%b all=%b last=%b want all 0", out_valid, y, y_any, y_all, out_last);
        else nPass++;
        @(negedge clk);
        rst = 1'b0;
        mValid = 1'b0; mAcc = '0; sb.delete();
        #1;
        nChecks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        else nPass++;
        if (e.y !== 8'h3C) $display("[TB] model preload value unexpected %h", e.y);
    endtask

    task automatic test_ops();
        logic [W-1:0] table_y [7];
        exp_t e;
        table_y = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 8'hA5, 8'h0F, 3'(i), 1'b0, 1'b1);
            stepClock();
            e = frontOrX();
            nChecks++;
            if (out_valid !== 1'b1 || y !== table_y[i] || y_any !== 1'b1 || y_all !== 1'b0 || {y, y_any, y_all, out_last} !== e)
                $display("[TB] FAIL op%0d: valid=%b y=%h any=%b all=%b want y=%h any=1 all=0", i, out_valid, y, y_any, y_all, table_y[i]);
            else nPass++;
        end
    endtask

    task automatic test_accumulate();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic [W-1:0] ty [4];
        logic [3:0]   tl;
        exp_t e;
        ta = '{8'h01, 8'h04, 8'h00, 8'h10};
        tb = '{8'h02, 8'h00, 8'h80, 8'h00};
        ty = '{8'h03, 8'h07, 8'h87, 8'h10};
        tl = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, ta[i], tb[i], 3'd7, tl[i], 1'b1);
            stepClock();
            e = frontOrX();
            nChecks++;
            if (out_valid !== 1'b1 || y !== ty[i] || out_last !== tl[i] || {y, y_any, y_all, out_last} !== e)
                $display("[TB] FAIL acc%0d: valid=%b y=%h last=%b want y=%h last=%b", i, out_valid, y, out_last, ty[i], tl[i]);
            else nPass++;
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        applyStimulus(1'b1, 8'hA5, 8'h0F, 3'd1, 1'b0, 1'b1);
        stepClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h01, 8'h02, 3'd7, 1'b0, 1'b0);
            #1;
            nChecks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 8'hAF)
                $display("[TB] FAIL stall%0d: in_ready=%b valid=%b y=%h want 0 1 af", i, in_ready, out_valid, y);
            else nPass++;
            stepClock();
        end
        applyStimulus(1'b1, 8'h01, 8'h02, 3'd7, 1'b0, 1'b1);
        #1;
        nChecks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL release_ready: got %b want 1", in_ready);
        else nPass++;
        stepClock();
        e = frontOrX();
        nChecks++;
        if (out_valid !== 1'b1 || y !== 8'h13 || {y, y_any, y_all, out_last} !== e)
            $display("[TB] FAIL release_result: valid=%b y=%h want y=13", out_valid, y);
        else nPass++;
        applyStimulus(1'b1, 8'h00, 8'h00, 3'd7, 1'b1, 1'b1);
        stepClock();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   good;
        good = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i + 1), 8'h00, 3'd1, 1'b0, 1'b1);
            stepClock();
            e = frontOrX();
            if (out_valid === 1'b1 && y === 8'(i + 1) && {y, y_any, y_all, out_last} === e) good++;
            else $display("[TB] beat %0d: valid=%b y=%h want %h", i, out_valid, y, 8'(i + 1));
        end
        nChecks++;
        if (good !== 16) $display("[TB] FAIL throughput: got %0d good beats want 16", good);
        else nPass++;
    endtask

    task automatic test_reductions();
        applyStimulus(1'b1, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b1);
        stepClock();
        nChecks++;
        if (out_valid !== 1'b1 || y !== 8'hFF || y_any !== 1'b1 || y_all !== 1'b1)
            $display("[TB] FAIL red_and: y=%h any=%b all=%b want ff 1 1", y, y_any, y_all);
        else nPass++;
        applyStimulus(1'b1, 8'hFF, 8'hFF, 3'd4, 1'b0, 1'b1);
        stepClock();
        nChecks++;
        if (out_valid !== 1'b1 || y !== 8'h00 || y_any !== 1'b0 || y_all !== 1'b0)
            $display("[TB] FAIL red_nor: y=%h any=%b all=%b want 00 0 0", y, y_any, y_all);
        else nPass++;
        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        stepClock();
        nChecks++;
        if (out_valid !== 1'b0 || y !== 8'h00) $display("[TB] FAIL drain: valid=%b y=%h want 0 00", out_valid, y);
        else nPass++;
    endtask

    // Run every scenario in order, then report
    initial begin
        nChecks = 0;
        nPass   = 0;
        test_reset();
        test_ops();
        test_accumulate();
        test_backpressure();
        test_back_to_back();
        test_reductions();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
